// File: rtl/store_checker_pkg.sv
// Shared types and defaults for the store result checker: verdict encodings,
// the status type and the default addresses/values.
package store_checker_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } status_t;

    localparam logic [31:0] DEF_RESULT_ADDR    = 32'd100;
    localparam logic [31:0] DEF_RESULT_VALUE   = 32'd25;
    localparam logic [31:0] DEF_SCRATCH_ADDR   = 32'd96;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 100;
    localparam int unsigned DEF_LOG_DEPTH      = 4;
    localparam int unsigned LOG_ENTRY_W        = 64;

endpackage

// File: rtl/store_result_checker_if.sv
// Data-store bus of the core. The core side drives it; the checker only snoops.
interface store_result_checker_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] write_data;

    modport master (output MemWrite, output DataAdr, output write_data);
    modport slave  (input  MemWrite, input  DataAdr, input  write_data);
endinterface

// File: rtl/store_log_fifo.sv
// Synchronous FIFO with a registered head (valid/ready pop) and drop-on-full push.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module store_log_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_inc;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             pop, push_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        full       = (count_q == CW'(DEPTH));
        pop        = valid_q && pop_ready;
        push_ok    = push_valid && (!full || pop);
        rd_ptr_inc = ptr_inc(rd_ptr_q);
        wr_ptr_d   = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_inc : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop) count_d = count_q + CW'(1);
        if (pop && !push_ok) count_d = count_q - CW'(1);
        // Head register tracks the entry that will sit at rd_ptr after this edge.
        head_d = head_q;
        if (pop) begin
            if (count_q > CW'(1)) head_d = mem_q[rd_ptr_inc];
            else if (push_ok)     head_d = push_data;
        end else if (count_q == '0 && push_ok) begin
            head_d = push_data;
        end
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign pop_valid = valid_q;
    assign pop_data  = head_q;
endmodule

// File: rtl/store_result_checker.sv
// Snoops the store bus and reaches a sticky PASS/FAIL/TIMEOUT verdict.
// Optional store log enabled by defining STORE_RESULT_CHECKER_LOG_EN.
module store_result_checker
    import store_checker_pkg::*;
#(
    parameter logic [31:0] RESULT_ADDR    = DEF_RESULT_ADDR,
    parameter logic [31:0] RESULT_VALUE   = DEF_RESULT_VALUE,
    parameter logic [31:0] SCRATCH_ADDR   = DEF_SCRATCH_ADDR,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned LOG_DEPTH      = DEF_LOG_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    store_result_checker_if.slave  bus,
    output logic [1:0]             status,
    output logic                   done,
    output logic [31:0]            fail_adr,
    output logic [31:0]            fail_data,
    output logic [15:0]            store_count
`ifdef STORE_RESULT_CHECKER_LOG_EN
    ,
    output logic                   log_valid,
    input  logic                   log_ready,
    output logic [31:0]            log_adr,
    output logic [31:0]            log_data
`endif
);
    localparam int CYC_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT_CYCLES - 1);

    if (TIMEOUT_CYCLES < 2 || LOG_DEPTH < 1 || (LOG_DEPTH & (LOG_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("store_result_checker: TIMEOUT_CYCLES must be >= 2 and LOG_DEPTH a power of two");
    end

    status_t          state_q, state_d;
    logic             done_q, done_d;
    logic [CYC_W-1:0] cycle_q, cycle_d;
    logic [15:0]      store_count_q, store_count_d;
    logic [31:0]      fail_adr_q, fail_adr_d, fail_data_q, fail_data_d;
    logic             run_store;

    always_comb begin
        state_d       = state_q;
        cycle_d       = cycle_q;
        store_count_d = store_count_q;
        fail_adr_d    = fail_adr_q;
        fail_data_d   = fail_data_q;
        run_store     = (state_q == ST_RUN) && bus.MemWrite;
        if (state_q == ST_RUN) begin
            if (cycle_q != CYC_LAST) cycle_d = cycle_q + CYC_W'(1);
            if (bus.MemWrite) begin
                if (store_count_q != 16'hFFFF) store_count_d = store_count_q + 16'd1;
                if (bus.DataAdr == RESULT_ADDR && bus.write_data == RESULT_VALUE) begin
                    state_d = ST_PASS;
                end else if (bus.DataAdr != SCRATCH_ADDR) begin
                    state_d     = ST_FAIL;
                    fail_adr_d  = bus.DataAdr;
                    fail_data_d = bus.write_data;
                end
            end
            // A decisive store on the last cycle takes precedence over the timeout.
            if (state_d == ST_RUN && cycle_q == CYC_LAST) state_d = ST_TIMEOUT;
        end
        done_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            done_q        <= 1'b0;
            cycle_q       <= '0;
            store_count_q <= '0;
            fail_adr_q    <= '0;
            fail_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            cycle_q       <= cycle_d;
            store_count_q <= store_count_d;
            fail_adr_q    <= fail_adr_d;
            fail_data_q   <= fail_data_d;
        end
    end

    assign status      = state_q;
    assign done        = done_q;
    assign fail_adr    = fail_adr_q;
    assign fail_data   = fail_data_q;
    assign store_count = store_count_q;

`ifdef STORE_RESULT_CHECKER_LOG_EN
    logic        log_full, log_pop, log_push;
    logic [63:0] log_head;

    assign log_pop  = log_valid && log_ready;
    assign log_push = run_store && (!log_full || log_pop);

    store_log_fifo #(
        .DEPTH (LOG_DEPTH),
        .WIDTH (LOG_ENTRY_W)
    ) u_log (
        .clk        (clk),
        .reset      (reset),
        .push_valid (log_push),
        .push_data  ({bus.DataAdr, bus.write_data}),
        .pop_ready  (log_ready),
        .pop_valid  (log_valid),
        .pop_data   (log_head),
        .full       (log_full)
    );

    assign log_adr  = log_head[63:32];
    assign log_data = log_head[31:0];
`else
    logic unused_run_store;
    assign unused_run_store = run_store;
`endif
endmodule
